// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Low-order mask of n ones; patterns never exceed 32 bits.
  function automatic logic [31:0] mask_of(input int unsigned n);
    if (n >= 32)
      return '1;
    else
      return (32'h1 << n) - 32'h1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector with qualified input, overlap
// control and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int              PAT_W   = 8,
  parameter int              CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1011),
  parameter int              DEF_LEN = 4,
  parameter bit              DEF_OVL = 1'b1,
  localparam int             LEN_W   = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             X,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             Y,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  // Only PAT_W-1 past bits are stored; the incoming bit completes the window.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] nh;
  logic [31:0]      mask;
  logic [31:0]      diff;
  logic [LEN_W:0]   fill_inc;
  logic             cfg_ok;
  logic             match;

  assign nh       = {hist, X};
  assign mask     = mask_of(32'(len));
  assign diff     = 32'(nh ^ pat);
  assign fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

  // A configuration load always swallows a coincident sample.
  assign match = x_valid && !cfg_load
              && (fill_inc >= {1'b0, len})
              && ((diff & mask) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pat     <= DEF_PAT;
      len     <= LEN_W'(DEF_LEN);
      ovl     <= DEF_OVL;
      hist    <= '0;
      fill    <= '0;
      Y       <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      Y       <= match;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (cfg_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          hist <= '0;
          fill <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (x_valid) begin
        hist <= nh[PAT_W-2:0];
        if (match && (ovl == OVL_OFF))
          fill <= '0;
        else if (fill < LEN_W'(PAT_W))
          fill <= fill_inc[LEN_W-1:0];
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk  (clk),
    .reset(reset),
    .clr  (count_clr),
    .inc  (match),
    .q    (match_count)
  );

endmodule
